// File: rtl/bootram_pkg.sv
// Shared types and constants for the boot RAM loader: FSM states, default
// frame marker and the number of byte lanes behind one 32-bit word.
package bootram_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    CSUM,
    DONE,
    ERR
  } state_e;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         LANES     = 4;

endpackage

// File: rtl/bootram_loader_if.sv
// Byte-stream input and boot RAM write port of the loader.
// The loader takes the slave view; the UART/RAM side takes the master view.
interface bootram_loader_if
  import bootram_pkg::*;
#(
  parameter int ADDR_W = 11
);

  logic              s_valid;
  logic              s_ready;
  logic [7:0]        s_data;
  logic [ADDR_W-1:0] ram_ad;
  logic [7:0]        ram_din;
  logic [LANES-1:0]  ram_ce;
  logic [LANES-1:0]  ram_wre;

  modport master (
    output s_valid, s_data,
    input  s_ready, ram_ad, ram_din, ram_ce, ram_wre
  );

  modport slave (
    input  s_valid, s_data,
    output s_ready, ram_ad, ram_din, ram_ce, ram_wre
  );

endinterface

// File: rtl/bootram_lane_dec.sv
// Registered decoder from a frame byte index to word address, one-hot lane
// write enable and write data; outputs lag the accepted byte by one cycle.
module bootram_lane_dec
  import bootram_pkg::*;
#(
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              we_i,
  input  logic [ADDR_W+1:0] idx_i,
  input  logic [7:0]        data_i,
  output logic [ADDR_W-1:0] ram_ad_o,
  output logic [7:0]        ram_din_o,
  output logic [LANES-1:0]  ram_wre_o
);

  logic [ADDR_W-1:0] ad_q, ad_d;
  logic [7:0]        din_q, din_d;
  logic [LANES-1:0]  wre_q, wre_d;

  always_comb begin
    ad_d  = ad_q;
    din_d = din_q;
    wre_d = '0;
    if (we_i) begin
      ad_d              = idx_i[ADDR_W+1:2];
      din_d             = data_i;
      wre_d[idx_i[1:0]] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ad_q  <= '0;
      din_q <= '0;
      wre_q <= '0;
    end else begin
      ad_q  <= ad_d;
      din_q <= din_d;
      wre_q <= wre_d;
    end
  end

  assign ram_ad_o  = ad_q;
  assign ram_din_o = din_q;
  assign ram_wre_o = wre_q;

endmodule

// File: rtl/bootram_loader.sv
// Framed UART byte-stream writer for the four boot RAM byte lanes with an
// 8-bit checksum; holds the CPU in reset while a load is pending or failed.
module bootram_loader #(
  parameter int         ADDR_W      = 11,
  parameter int         TIMEOUT_CYC = 1000000,
  parameter logic [7:0] SYNC_BYTE   = bootram_pkg::SYNC_BYTE
) (
  input  logic            clk,
  input  logic            resetn,
  bootram_loader_if.slave bus,
  output logic            cpu_hold,
  output logic            done,
  output logic            error
);

  import bootram_pkg::*;

  localparam int          IW      = ADDR_W + 2;
  localparam int          TW      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [16:0] MAX_LEN = 17'd1 << ADDR_W;

  state_e            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [IW-1:0]     last_q, last_d;
  logic [7:0]        sum_q, sum_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [TW-1:0]     idle_q, idle_d;
  logic              hold_q, hold_d;
  logic              err_q, err_d;
  logic              wr_en;
  logic              in_frame;
  logic              timed_out;
  logic [15:0]       len_w;
  logic              len_ok;
  logic [ADDR_W-1:0] dec_ad;
  logic [7:0]        dec_din;
  logic [LANES-1:0]  dec_wre;

  assign len_w     = {bus.s_data, len_lo_q};
  assign len_ok    = (len_w != 16'd0) && ({1'b0, len_w} <= MAX_LEN);
  assign in_frame  = state_q inside {LEN_LO, LEN_HI, DATA, CSUM};
  assign timed_out = (idle_q == TW'(TIMEOUT_CYC - 1));

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    last_d   = last_q;
    sum_d    = sum_q;
    len_lo_d = len_lo_q;
    idle_d   = '0;
    hold_d   = hold_q;
    err_d    = err_q;
    wr_en    = 1'b0;

    if (in_frame) idle_d = bus.s_valid ? '0 : idle_q + TW'(1);

    unique case (state_q)
      IDLE: begin
        if (bus.s_valid && bus.s_data == SYNC_BYTE) begin
          state_d = LEN_LO;
          hold_d  = 1'b1;
          err_d   = 1'b0;
          idx_d   = '0;
          sum_d   = '0;
        end
      end
      LEN_LO: begin
        if (bus.s_valid) begin
          len_lo_d = bus.s_data;
          state_d  = LEN_HI;
        end
      end
      LEN_HI: begin
        if (bus.s_valid) begin
          if (len_ok) begin
            last_d  = IW'({len_w - 16'd1, 2'b11});
            state_d = DATA;
          end else begin
            state_d = ERR;
          end
        end
      end
      DATA: begin
        if (bus.s_valid) begin
          wr_en = 1'b1;
          sum_d = sum_q + bus.s_data;
          if (idx_q == last_q) state_d = CSUM;
          else                 idx_d   = idx_q + IW'(1);
        end
      end
      CSUM: begin
        if (bus.s_valid) state_d = (bus.s_data == sum_q) ? DONE : ERR;
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A byte arriving in the expiry cycle keeps the frame alive.
    if (in_frame && !bus.s_valid && timed_out) state_d = ERR;
    if (state_d == ERR)  err_d  = 1'b1;
    if (state_d == DONE) hold_d = 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      last_q   <= '0;
      sum_q    <= '0;
      len_lo_q <= '0;
      idle_q   <= '0;
      hold_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      last_q   <= last_d;
      sum_q    <= sum_d;
      len_lo_q <= len_lo_d;
      idle_q   <= idle_d;
      hold_q   <= hold_d;
      err_q    <= err_d;
    end
  end

  bootram_lane_dec #(.ADDR_W(ADDR_W)) u_dec (
    .clk       (clk),
    .resetn    (resetn),
    .we_i      (wr_en),
    .idx_i     (idx_q),
    .data_i    (bus.s_data),
    .ram_ad_o  (dec_ad),
    .ram_din_o (dec_din),
    .ram_wre_o (dec_wre)
  );

  assign bus.s_ready = 1'b1;
  assign bus.ram_ad  = dec_ad;
  assign bus.ram_din = dec_din;
  assign bus.ram_wre = dec_wre;
  assign bus.ram_ce  = dec_wre;
  assign cpu_hold    = hold_q;
  assign error       = err_q;
  assign done        = (state_q == DONE);

endmodule

// File: tb/tb_bootram_loader.sv
// Bench for bootram_loader: directed and random frames scored against a
// frame-level model of the expected RAM writes, done/error and cpu_hold.
module tb_bootram_loader;

  localparam int ADDR_W = 11;
  localparam int TO     = 16;

  logic clk    = 1'b0;
  logic resetn = 1'b1;
  logic cpu_hold, done, error;

  bootram_loader_if #(.ADDR_W(ADDR_W)) bus ();

  bootram_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TO), .SYNC_BYTE(8'hA5)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .bus      (bus),
    .cpu_hold (cpu_hold),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]        lane;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
    int unsigned       tag;
  } wr_t;

  int          checks   = 0;
  int          failures = 0;
  int unsigned pcnt     = 0;
  wr_t         wq[$];
  int unsigned tagq[$];
  logic [7:0]  fr[$];
  int          done_cnt;
  bit          ce_bad;

  always @(posedge clk) pcnt <= pcnt + 1;

  // Observed writes are tagged with the edge count so byte-to-write lag is checkable.
  always @(negedge clk) begin
    wr_t w;
    if (resetn) begin
      if (bus.ram_ce !== bus.ram_wre) ce_bad = 1'b1;
      if (bus.ram_wre !== 4'b0000) begin
        if (!$onehot(bus.ram_wre)) ce_bad = 1'b1;
        w.lane = 2'd0;
        for (int l = 0; l < 4; l++) if (bus.ram_wre[l]) w.lane = 2'(l);
        w.addr = bus.ram_ad;
        w.data = bus.ram_din;
        w.tag  = pcnt;
        wq.push_back(w);
      end
      if (done === 1'b1) done_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_s_ready"},  32'(bus.s_ready), 32'd1);
    chk({p, "_ram_wre"},  32'(bus.ram_wre), 32'd0);
    chk({p, "_ram_ce"},   32'(bus.ram_ce),  32'd0);
    chk({p, "_ram_ad"},   32'(bus.ram_ad),  32'd0);
    chk({p, "_ram_din"},  32'(bus.ram_din), 32'd0);
    chk({p, "_cpu_hold"}, 32'(cpu_hold),    32'd0);
    chk({p, "_done"},     32'(done),        32'd0);
    chk({p, "_error"},    32'(error),       32'd0);
  endtask

  // Called at a negedge; each byte is presented for one cycle after an optional gap.
  task automatic send_bytes(input int maxgap);
    int g;
    tagq.delete();
    for (int k = 0; k < fr.size(); k++) begin
      g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
      repeat (g) begin
        bus.s_valid = 1'b0;
        @(negedge clk);
      end
      bus.s_valid = 1'b1;
      bus.s_data  = fr[k];
      tagq.push_back(pcnt + 1);
      @(negedge clk);
    end
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
  endtask

  task automatic build(input int len, input bit bad);
    logic [7:0] d, s;
    fr.delete();
    fr.push_back(8'hA5);
    fr.push_back(8'(len));
    fr.push_back(8'(len >> 8));
    s = 8'h00;
    for (int k = 0; k < 4 * len; k++) begin
      d = (k == 5) ? 8'hA5 : 8'($urandom);
      fr.push_back(d);
      s = s + d;
    end
    fr.push_back(bad ? s + 8'd1 : s);
  endtask

  // Frame-level expectation: data byte k lands in lane k%4 at word k/4.
  task automatic check_frame(input string nm);
    int len, ndata, nchk, nbad, sum;
    bit len_ok, complete, exp_done;
    len      = int'(fr[1]) + 256 * int'(fr[2]);
    len_ok   = (len >= 1) && (len <= (1 << ADDR_W));
    ndata    = 0;
    if (len_ok) ndata = (fr.size() - 3 < 4 * len) ? fr.size() - 3 : 4 * len;
    complete = len_ok && (fr.size() >= 4 * len + 4);
    sum      = 0;
    for (int k = 0; k < ndata; k++) sum += int'(fr[3 + k]);
    exp_done = complete && (fr[4 * len + 3] == 8'(sum));
    nchk     = (wq.size() < ndata) ? wq.size() : ndata;
    nbad     = 0;
    for (int k = 0; k < nchk; k++) begin
      if (wq[k].lane !== 2'(k % 4) || wq[k].addr !== ADDR_W'(k / 4) ||
          wq[k].data !== fr[3 + k] || wq[k].tag != tagq[3 + k]) nbad++;
    end
    chk({nm, "_nwrites"},  32'(wq.size()), 32'(ndata));
    chk({nm, "_wrbad"},    32'(nbad),      32'd0);
    chk({nm, "_done_cnt"}, 32'(done_cnt),  exp_done ? 32'd1 : 32'd0);
    chk({nm, "_error"},    32'(error),     exp_done ? 32'd0 : 32'd1);
    chk({nm, "_cpu_hold"}, 32'(cpu_hold),  exp_done ? 32'd0 : 32'd1);
    chk({nm, "_ce_wre"},   32'(ce_bad),    32'd0);
  endtask

  task automatic clear_mon();
    wq.delete();
    done_cnt = 0;
    ce_bad   = 1'b0;
  endtask

  task automatic run(input string nm, input int maxgap, input int settle);
    clear_mon();
    send_bytes(maxgap);
    repeat (settle) @(negedge clk);
    check_frame(nm);
  endtask

  task automatic noise(input string nm);
    clear_mon();
    fr = '{8'h00, 8'hFF, 8'h5A};
    send_bytes(0);
    repeat (3) @(negedge clk);
    chk({nm, "_nwrites"},  32'(wq.size()), 32'd0);
    chk({nm, "_cpu_hold"}, 32'(cpu_hold),  32'd0);
    chk({nm, "_done_cnt"}, 32'(done_cnt),  32'd0);
    chk({nm, "_error"},    32'(error),     32'd0);
  endtask

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
    clear_mon();
    #2 resetn = 1'b0;
    @(negedge clk);
    chk_reset("rst");
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    fr = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
           8'h55, 8'h66, 8'h77, 8'h88, 8'h64};
    run("good", 0, 4);
    noise("noise");

    fr = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
           8'h55, 8'h66, 8'h77, 8'h88, 8'h65};
    run("badsum", 2, 4);

    fr = '{8'hA5, 8'h00, 8'h00};
    run("len0", 0, 4);
    fr = '{8'hA5, 8'h01, 8'h08};
    run("len2049", 0, 4);

    fr = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33};
    clear_mon();
    send_bytes(0);
    repeat (14) @(negedge clk);
    chk("timeout_early_error", 32'(error), 32'd0);
    repeat (4) @(negedge clk);
    chk("timeout_late_error", 32'(error), 32'd1);
    check_frame("timeout");

    build(3, 1'b0);
    run("after_timeout", 3, 4);

    build(4, 1'b0);
    run("stream", 0, 4);

    for (int f = 0; f < 6; f++) begin
      build(int'($urandom_range(8, 1)), 1'($urandom_range(1, 0)));
      run($sformatf("rand%0d", f), 5, 4);
    end

    build(2048, 1'b0);
    run("len2048", 0, 4);
    chk("len2048_last_lane", 32'(wq.size() > 0 ? wq[wq.size()-1].lane : 2'd0), 32'd3);
    chk("len2048_last_addr", 32'(wq.size() > 0 ? wq[wq.size()-1].addr : '0), 32'h7FF);

    build(4, 1'b0);
    while (fr.size() > 9) void'(fr.pop_back());
    clear_mon();
    send_bytes(0);
    chk("midrst_pre_wre",  32'(bus.ram_wre != 4'b0000), 32'd1);
    chk("midrst_pre_hold", 32'(cpu_hold), 32'd1);
    #1 resetn = 1'b0;
    #1 chk_reset("midrst");
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    noise("postrst_noise");
    build(2, 1'b0);
    run("postrst_good", 1, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
